match_window_counter: RTL and testbench



---
 rtl/match_window_counter.sv | 114 +++++++++++
 tb/tb_match_window_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/match_window_counter.sv
// Counts detector match pulses over a fixed WINDOW-cycle frame and publishes count/alarm with a done pulse.
// Optional first-hit position capture is enabled with `define MATCH_FIRSTPOS_EN.
module match_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5,
    parameter int THRESH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_hit,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count,
    output logic             o_alarm
`ifdef MATCH_FIRSTPOS_EN
   ,output logic [7:0]       o_first_pos,
    output logic             o_first_vld
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0]       LAST = 8'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_pos;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_nxt;
    logic             w_last;
    logic             w_open;

    always_comb begin
        w_state_nxt = r_state;
        w_open      = 1'b0;
        w_last      = (r_state == S_RUN) && (r_pos == LAST);
        w_acc_nxt   = (i_hit && (r_acc != MAX)) ? r_acc + 1'b1 : r_acc;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_nxt = S_RUN;
                w_open      = 1'b1;
            end
            S_RUN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                // back-to-back frames skip IDLE entirely
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_open      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pos   <= 8'd0;
            r_acc   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_count <= '0;
            o_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            o_busy  <= (w_state_nxt == S_RUN);
            o_done  <= w_last;
            if (w_open) begin
                r_acc <= '0;
                r_pos <= 8'd0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_pos <= r_pos + 8'd1;
            end
            // final sample is folded in on the closing edge
            if (w_last) begin
                o_count <= w_acc_nxt;
                o_alarm <= (w_acc_nxt >= THR);
            end
        end
    end

`ifdef MATCH_FIRSTPOS_EN
    logic       r_seen;
    logic [7:0] r_cap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seen      <= 1'b0;
            r_cap       <= 8'd0;
            o_first_pos <= 8'd0;
            o_first_vld <= 1'b0;
        end else if (w_open) begin
            r_seen <= 1'b0;
            r_cap  <= 8'd0;
        end else if (r_state == S_RUN) begin
            if (i_hit && !r_seen) begin
                r_seen <= 1'b1;
                r_cap  <= r_pos;
            end
            if (w_last) begin
                o_first_vld <= r_seen | i_hit;
                o_first_pos <= r_seen ? r_cap : (i_hit ? r_pos : 8'd0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench for match_window_counter: vector table, hand sequences and a random frame model.
module tb_match_window_counter;
    localparam int W = 16;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, hit = 1'b0;
    logic       busy, done, alarm;
    logic [4:0] count;
    logic       s_start = 1'b0, s_hit = 1'b0;
    logic       s_busy, s_done, s_alarm;
    logic [1:0] s_count;
`ifdef MATCH_FIRSTPOS_EN
    logic [7:0] fpos, s_fpos;
    logic       fvld, s_fvld;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_window_counter #(.WINDOW(16), .CNT_W(5), .THRESH(3)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_hit(hit),
        .o_busy(busy), .o_done(done), .o_count(count), .o_alarm(alarm)
`ifdef MATCH_FIRSTPOS_EN
       ,.o_first_pos(fpos), .o_first_vld(fvld)
`endif
    );

    match_window_counter #(.WINDOW(8), .CNT_W(2), .THRESH(3)) u_sat (
        .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_hit(s_hit),
        .o_busy(s_busy), .o_done(s_done), .o_count(s_count), .o_alarm(s_alarm)
`ifdef MATCH_FIRSTPOS_EN
       ,.o_first_pos(s_fpos), .o_first_vld(s_fvld)
`endif
    );

    typedef struct {
        logic [15:0] pat;
        int          cnt;
        bit          alm;
        int          fp;
        bit          fv;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: frame statistic straight from the hit vector
    task automatic model(input logic [15:0] pat, output int cnt, output bit alm,
                         output int fp, output bit fv);
        cnt = $countones(pat);
        if (cnt > 31) cnt = 31;
        alm = (cnt >= 3);
        fp  = 0;
        fv  = 1'b0;
        for (int i = 0; i < W; i++)
            if (pat[i] && !fv) begin
                fp = i;
                fv = 1'b1;
            end
    endtask

    // caller is just past an edge with the DUT in IDLE or DONE
    task automatic run_win(input logic [15:0] pat, input bit noise, input int spulse,
                           input int ecnt, input bit ealm, input int efp, input bit efv);
        start = 1'b1;
        hit   = noise ? 1'($urandom % 2) : 1'b0;
        tick;
        chk("busy_open", busy, 1);
        chk("done_open", done, 0);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            hit   = pat[i];
            start = (i == spulse) || (noise && ($urandom % 2 == 1));
            tick;
            if (i < W - 1) begin
                chk("busy_run", busy, 1);
                chk("done_early", done, 0);
            end
        end
        start = 1'b0;
        hit   = 1'b0;
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("count", count, ecnt);
        chk("alarm", alarm, ealm);
`ifdef MATCH_FIRSTPOS_EN
        chk("first_pos", fpos, efp);
        chk("first_vld", fvld, efv);
`endif
    endtask

    initial begin
        int  c, p;
        bit  a, v;
        logic [15:0] pat;

        tbl[0] = '{16'b1000_0000_1000_0100, 3, 1, 2, 1};
        tbl[1] = '{16'h0000, 0, 0, 0, 0};
        tbl[2] = '{16'h0001, 1, 0, 0, 1};
        tbl[3] = '{16'hFFFF, 16, 1, 0, 1};
        tbl[4] = '{16'hC000, 2, 0, 14, 1};
        tbl[5] = '{16'h8000, 1, 0, 15, 1};
        tbl[6] = '{16'h00F0, 4, 1, 4, 1};

        tick;
        tick;
        rst = 1'b0;
        hit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_count", count, 0);
            chk("idle_alarm", alarm, 0);
        end
        hit = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_win(tbl[k].pat, 1'b0, -1, tbl[k].cnt, tbl[k].alm, tbl[k].fp, tbl[k].fv);
            tick;
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("held_count", count, tbl[k].cnt);
        end

        // back-to-back: second start lands in the DONE cycle
        run_win(16'h0001, 1'b0, -1, 1, 0, 0, 1);
        run_win(16'h0000, 1'b0, -1, 0, 0, 0, 0);
        tick;

        // start mid-window is ignored; one done at the original end
        run_win(16'h0421, 1'b0, 5, 3, 1, 0, 1);
        tick;
        chk("midstart_done", done, 0);
        chk("midstart_busy", busy, 0);

        // reset at window index 5 after two counted hits
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hit = (i < 2);
            tick;
        end
        hit = 1'b0;
        rst = 1'b1;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_alarm", alarm, 0);
`ifdef MATCH_FIRSTPOS_EN
        chk("rst_fpos", fpos, 0);
        chk("rst_fvld", fvld, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick;
            chk("rst_no_done", done, 0);
        end
        run_win(16'h0008, 1'b0, -1, 1, 0, 3, 1);
        tick;

        // saturation instance: WINDOW=8, CNT_W=2, THRESH=3
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        s_hit   = 1'b1;
        for (int i = 0; i < 8; i++) tick;
        chk("sat_done", s_done, 1);
        chk("sat_count", s_count, 3);
        chk("sat_alarm", s_alarm, 1);
        s_start = 1'b1;
        s_hit   = 1'b0;
        tick;
        s_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_hit = (i < 2);
            tick;
        end
        s_hit = 1'b0;
        chk("sat2_done", s_done, 1);
        chk("sat2_count", s_count, 2);
        chk("sat2_alarm", s_alarm, 0);
        tick;

        // random frames with noise on start/hit outside counted samples
        for (int k = 0; k < 25; k++) begin
            int gap;
            gap = $urandom % 3;
            for (int g = 0; g < gap; g++) begin
                hit = 1'($urandom % 2);
                tick;
                chk("rnd_idle_done", done, 0);
            end
            pat = 16'($urandom);
            if (k % 5 == 0) pat = pat & 16'($urandom);
            model(pat, c, a, p, v);
            run_win(pat, 1'b1, -1, c, a, p, v);
        end
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
